// File: rtl/pc_pkg.sv
// Shared types, widths and the next-PC helper for the fetch sequencer.
package pc_pkg;

   localparam int PC_W   = 12;
   localparam int LUT_AW = 6;
   localparam int CNT_W  = 16;

   // Sequencer states kept as plain constants so netlists stay readable.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t HALT = 2'd2;

   // Relative branch or sequential step; both wrap modulo 2^PC_W.
   function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc,
                                                input logic [PC_W-1:0] target,
                                                input logic            take);
      return take ? pc + target : pc + PC_W'(1);
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC adder/mux plus zero-offset detect.
module pc_next_calc
   import pc_pkg::PC_W;
   import pc_pkg::next_pc;
#(
   parameter int D = 12
) (
   input  logic [D-1:0] pc,
   input  logic [D-1:0] target,
   input  logic         take,
   output logic [D-1:0] nxt,
   output logic         zero_tgt
);

   // Two's-complement add gives the signed relative target for free.
   generate
      if (D == PC_W) begin : g_pkg
         assign nxt = next_pc(pc, target, take);
      end else begin : g_gen
         assign nxt = take ? pc + target : pc + D'(1);
      end
   endgenerate

   assign zero_tgt = (target == '0);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer: start/halt handshake, stalls and
// single-cycle relative branches through an external offset table.
module pc_fetch_ctrl
   import pc_pkg::state_t;
   import pc_pkg::IDLE;
   import pc_pkg::RUN;
   import pc_pkg::HALT;
#(
   parameter int D      = 12,
   parameter int LUT_AW = 6,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [D-1:0]      start_addr,
   input  logic              stall,
   input  logic              branch_en,
   input  logic [LUT_AW-1:0] lut_idx,
   input  logic              halt_req,
   output logic [LUT_AW-1:0] lut_addr,
   input  logic [D-1:0]      lut_target,
   output logic [D-1:0]      prog_ctr,
   output logic              fetch_valid,
   output logic              done,
   output logic              bad_target,
   output logic [CNT_W-1:0]  branch_count
);

   state_t       state;
   logic [D-1:0] nxt;
   logic         zero_tgt;

   // Table lookup is purely combinational, so the index passes straight through.
   assign lut_addr = lut_idx;

   pc_next_calc #(.D(D)) u_next (
      .pc       (prog_ctr),
      .target   (lut_target),
      .take     (branch_en),
      .nxt      (nxt),
      .zero_tgt (zero_tgt)
   );

   assign fetch_valid = (state == RUN);
   assign done        = (state == HALT);

   // FSM and PC/counter registers; halt > stall > branch > increment in RUN.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         prog_ctr     <= '0;
         bad_target   <= 1'b0;
         branch_count <= '0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  state <= HALT;
               end else if (stall) begin
                  state <= RUN;
               end else if (branch_en) begin
                  if (zero_tgt) begin
                     // A zero offset would self-loop forever: flag and stop.
                     bad_target <= 1'b1;
                     state      <= HALT;
                  end else begin
                     prog_ctr <= nxt;
                     if (branch_count != '1)
                        branch_count <= branch_count + CNT_W'(1);
                  end
               end else begin
                  prog_ctr <= nxt;
               end
            end
            default: begin
               // IDLE and HALT both wait for start; HALT otherwise freezes.
               if (start) begin
                  prog_ctr     <= start_addr;
                  branch_count <= '0;
                  bad_target   <= 1'b0;
                  state        <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios then random
// traffic, compared against a behavioural model and a bench-side offset table.
module tb_pc_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start, stall, branch_en, halt_req;
   logic [11:0] start_addr;
   logic [5:0]  lut_idx;
   logic [5:0]  lut_addr;
   logic [11:0] lut_target;
   logic [11:0] prog_ctr;
   logic        fetch_valid, done, bad_target;
   logic [15:0] branch_count;

   logic signed [11:0] lut [64];

   int n_chk  = 0;
   int n_fail = 0;

   // behavioural model
   bit m_run, m_halt, m_bad;
   int m_pc, m_cnt;

   always #5 Clk = ~Clk;

   assign lut_target = lut[lut_addr];

   pc_fetch_ctrl dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .start_addr   (start_addr),
      .stall        (stall),
      .branch_en    (branch_en),
      .lut_idx      (lut_idx),
      .halt_req     (halt_req),
      .lut_addr     (lut_addr),
      .lut_target   (lut_target),
      .prog_ctr     (prog_ctr),
      .fetch_valid  (fetch_valid),
      .done         (done),
      .bad_target   (bad_target),
      .branch_count (branch_count)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_outs();
      chk("prog_ctr", int'(prog_ctr), m_pc);
      chk("fetch_valid", int'(fetch_valid), int'(m_run));
      chk("done", int'(done), int'(m_halt));
      chk("bad_target", int'(bad_target), int'(m_bad));
      chk("branch_count", int'(branch_count), m_cnt);
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_bad = 0; m_pc = 0; m_cnt = 0;
   endtask

   // One clock: drive at negedge, advance model, check after the rising edge.
   task automatic cyc(input bit st, input int sa, input bit stl, input bit br,
                      input int idx, input bit hlt);
      int off;
      start = st; start_addr = sa[11:0]; stall = stl; branch_en = br;
      lut_idx = idx[5:0]; halt_req = hlt;
      #1;
      chk("lut_addr", int'(lut_addr), idx);
      if (!m_run) begin
         if (st) begin
            m_pc = sa; m_cnt = 0; m_bad = 0; m_run = 1; m_halt = 0;
         end
      end else if (hlt) begin
         m_run = 0; m_halt = 1;
      end else if (stl) begin
         // everything holds
      end else if (br) begin
         off = int'(lut[idx]);
         if (off == 0) begin
            m_bad = 1; m_run = 0; m_halt = 1;
         end else begin
            m_pc = (((m_pc + off) % 4096) + 4096) % 4096;
            if (m_cnt < 65535) m_cnt++;
         end
      end else begin
         m_pc = (m_pc + 1) % 4096;
      end
      @(posedge Clk);
      #1;
      chk_outs();
      @(negedge Clk);
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   // Reset asserted between edges must clear outputs without a clock.
   task automatic async_reset();
      #2;
      Reset = 1'b1;
      #1;
      model_reset();
      chk("async_rst_pc", int'(prog_ctr), 0);
      chk("async_rst_valid", int'(fetch_valid), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_bad", int'(bad_target), 0);
      chk("async_rst_cnt", int'(branch_count), 0);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         lut[i] = 12'($urandom_range(1, 4095));
         if ($urandom_range(0, 15) == 0) lut[i] = '0;
      end
      lut[16] = 12'sd14;
      lut[17] = -12'sd142;
      lut[14] = '0;

      Reset = 1'b1; start = 0; start_addr = '0; stall = 0; branch_en = 0;
      lut_idx = '0; halt_req = 0;
      model_reset();
      #12;
      chk_outs();
      @(negedge Clk);
      Reset = 1'b0;

      // sequential run from 5
      cyc(1, 5, 0, 0, 0, 0);
      repeat (3) idle_cyc();
      chk("seq_pc8", int'(prog_ctr), 8);

      // forward branch 20 -> 34
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 20, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 16, 0);
      chk("fwd_pc", int'(prog_ctr), 34);
      chk("fwd_cnt", int'(branch_count), 1);

      // backward branch with wrap 100 -> 4054
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 100, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 17, 0);
      chk("bwd_pc", int'(prog_ctr), 4054);

      // stall over branch for two cycles
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 50, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 16, 0);
      cyc(0, 0, 1, 1, 16, 0);
      chk("stall_pc", int'(prog_ctr), 50);
      cyc(0, 0, 0, 1, 16, 0);
      chk("stall_br_pc", int'(prog_ctr), 64);
      chk("stall_br_cnt", int'(branch_count), 1);

      // zero-offset branch
      cyc(0, 0, 0, 0, 0, 1);
      cyc(1, 30, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 14, 0);
      chk("zero_bad", int'(bad_target), 1);
      chk("zero_done", int'(done), 1);
      chk("zero_pc", int'(prog_ctr), 30);
      // HALT ignores branch/stall/halt
      cyc(0, 0, 1, 1, 16, 1);

      // halt at 9, restart from 0, then async reset at 3
      cyc(1, 9, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("halt_pc", int'(prog_ctr), 9);
      cyc(1, 0, 0, 0, 0, 0);
      repeat (3) idle_cyc();
      chk("restart_pc3", int'(prog_ctr), 3);
      // start while running is ignored
      cyc(1, 700, 0, 0, 0, 0);
      async_reset();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            async_reset();
         end else begin
            cyc($urandom_range(0, 7) == 0, int'($urandom_range(0, 4095)),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                int'($urandom_range(0, 63)), $urandom_range(0, 39) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
